// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : boot_pkg
//  Purpose : Shared definitions for the UART boot loader: loader state
//            encoding, frame-length field width and the default inter-byte
//            timeout.
//  Ports   : none (package)
//  Config  : BOOT_CHECKSUM_EN (used by uart_boot_loader; the CSUM state
//            encoding is always present so both builds share one state map)
//  Revision: 1.0 - initial release
// ============================================================================
package boot_pkg;

  // Width of the little-endian word-count field at the head of a frame.
  localparam int unsigned LEN_W = 16;

  // Default number of idle clocks tolerated between bytes of one frame.
  localparam int unsigned TIMEOUT_DEFAULT = 50000;

  typedef enum logic [2:0] {
    BOOT_IDLE   = 3'd0,
    BOOT_LEN_HI = 3'd1,
    BOOT_DATA   = 3'd2,
    BOOT_CSUM   = 3'd3,
    BOOT_DONE   = 3'd4,
    BOOT_ERR    = 3'd5
  } boot_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module  : uart_boot_loader_if
//  Purpose : Bundles the byte-receiver input, the instruction-memory write
//            port and the loader status lines of uart_boot_loader.
//  Signals : rx_en     receiver ready level; rising edge = new byte
//            rx_data   received byte, stable while rx_en high
//            mem_we    one-cycle instruction-memory write strobe
//            mem_addr  word write address (ADDR_W bits)
//            mem_wdata word write data
//            cpu_rst   active-high CPU reset
//            busy      frame in progress
//            done      last frame completed OK (sticky)
//            err       last frame aborted (sticky)
//  Modports: master - the loader (drives memory port and status)
//            slave  - the environment (drives receiver signals)
//  Revision: 1.0 - initial release
// ============================================================================
interface uart_boot_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              rx_en;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  rx_en,
    input  rx_data,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output cpu_rst,
    output busy,
    output done,
    output err
  );

  modport slave (
    output rx_en,
    output rx_data,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  cpu_rst,
    input  busy,
    input  done,
    input  err
  );
endinterface
`default_nettype wire

// File: rtl/boot_byte_edge.sv
`default_nettype none
// ============================================================================
//  Module  : boot_byte_edge
//  Purpose : Converts the receiver's rx_en ready level into a registered
//            one-cycle byte strobe and captures the accompanying byte.
//  Ports   : clk       system clock
//            rst       asynchronous active-high reset
//            rx_en     receiver ready level
//            rx_data   received byte
//            byte_stb  one-cycle pulse, one clock after rx_en rises
//            byte_data byte captured on the rising edge of rx_en
//  Revision: 1.0 - initial release
// ============================================================================
module boot_byte_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic [7:0] rx_data,
  output logic       byte_stb,
  output logic [7:0] byte_data
);

  logic       r_rx_en_q;
  logic       r_byte_stb;
  logic [7:0] r_byte_data;
  logic       w_rise;

  assign w_rise = rx_en & ~r_rx_en_q;

  // r_rx_en_q resets high so a receiver already idling high when reset is
  // released is not mistaken for a fresh byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_en_q   <= 1'b1;
      r_byte_stb  <= 1'b0;
      r_byte_data <= 8'h00;
    end else begin
      r_rx_en_q  <= rx_en;
      r_byte_stb <= w_rise;
      if (w_rise) begin
        r_byte_data <= rx_data;
      end
    end
  end

  assign byte_stb  = r_byte_stb;
  assign byte_data = r_byte_data;

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module  : uart_boot_loader
//  Purpose : Turns a UART byte stream into 32-bit instruction-memory word
//            writes and holds the CPU in reset until a program has loaded.
//            Frame: LEN_LO, LEN_HI (word count N), 4*N data bytes, each
//            word least-significant byte first.
//  Params  : ADDR_W    word-address width of instruction memory
//            BASE_ADDR word address of the first loaded word
//            TIMEOUT   max idle clocks between bytes inside a frame
//  Ports   : clk  system clock
//            rst  asynchronous active-high reset
//            bus  uart_boot_loader_if.master (receiver in, memory/status out)
//  Config  : BOOT_CHECKSUM_EN - when defined, a trailing byte equal to the
//            XOR of all preceding frame bytes must follow the data; a
//            mismatch ends the frame in error.
//  Revision: 1.0 - initial release
// ============================================================================
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  uart_boot_loader_if.master bus
);

  localparam logic [2:0] ST_IDLE   = BOOT_IDLE;
  localparam logic [2:0] ST_LEN_HI = BOOT_LEN_HI;
  localparam logic [2:0] ST_DATA   = BOOT_DATA;
  localparam logic [2:0] ST_CSUM   = BOOT_CSUM;
  localparam logic [2:0] ST_DONE   = BOOT_DONE;
  localparam logic [2:0] ST_ERR    = BOOT_ERR;

  localparam int unsigned        c_GAP_W     = $clog2(TIMEOUT + 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(TIMEOUT - 1);
  localparam logic [32:0]        c_MAX_WORDS = 33'd1 << ADDR_W;

  // --------------------------------------------------------------------------
  // Byte strobe generation
  // --------------------------------------------------------------------------
  logic       w_byte_stb;
  logic [7:0] w_byte;

  boot_byte_edge u_byte_edge (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (bus.rx_en),
    .rx_data   (bus.rx_data),
    .byte_stb  (w_byte_stb),
    .byte_data (w_byte)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]         r_state;
  logic [7:0]         r_len_lo;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic [1:0]         r_bcnt;
  logic [31:0]        r_wdata;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [c_GAP_W-1:0] r_gap;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]         r_csum;
`endif

  logic [LEN_W-1:0] w_len;
  logic             w_len_too_big;
  logic             w_busy;
  logic             w_timeout;
  logic             w_last_word;

  assign w_len         = {w_byte, r_len_lo};
  assign w_len_too_big = {17'd0, w_len} > c_MAX_WORDS;
  assign w_busy        = (r_state == ST_LEN_HI) || (r_state == ST_DATA) ||
                         (r_state == ST_CSUM);
  // A byte arriving in the very cycle the gap limit is hit is dropped:
  // the timeout check takes priority over the strobe in the FSM below.
  assign w_timeout     = w_busy && (r_gap >= c_GAP_LAST);
  assign w_last_word   = (r_idx + LEN_W'(1)) == r_len;

  // --------------------------------------------------------------------------
  // Inter-byte gap counter: runs only while a frame is open.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap <= '0;
    end else if (w_byte_stb || !w_busy || w_timeout) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + c_GAP_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM, word assembly and write strobe
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_len_lo <= 8'h00;
      r_len    <= '0;
      r_idx    <= '0;
      r_bcnt   <= 2'd0;
      r_wdata  <= 32'h0000_0000;
      r_we     <= 1'b0;
      r_addr   <= ADDR_W'(BASE_ADDR);
`ifdef BOOT_CHECKSUM_EN
      r_csum   <= 8'h00;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_timeout) begin
        // Any partially assembled word is simply abandoned.
        r_state <= ST_ERR;
      end else if (w_byte_stb) begin
        case (r_state)
          // A byte outside a frame always opens a new one as LEN_LO.
          ST_IDLE, ST_DONE, ST_ERR: begin
            r_len_lo <= w_byte;
            r_state  <= ST_LEN_HI;
`ifdef BOOT_CHECKSUM_EN
            r_csum   <= w_byte;
`endif
          end
          ST_LEN_HI: begin
            r_len  <= w_len;
            r_idx  <= '0;
            r_bcnt <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
            r_csum <= r_csum ^ w_byte;
`endif
            if (w_len == '0) begin
              r_state <= ST_DONE;
            end else if (w_len_too_big) begin
              r_state <= ST_ERR;
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_wdata <= {w_byte, r_wdata[31:8]};
            r_bcnt  <= r_bcnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            r_csum  <= r_csum ^ w_byte;
`endif
            if (r_bcnt == 2'd3) begin
              r_we   <= 1'b1;
              // Truncation to ADDR_W gives the modulo wrap of the address.
              r_addr <= ADDR_W'(BASE_ADDR + 32'(r_idx));
              r_idx  <= r_idx + LEN_W'(1);
              if (w_last_word) begin
`ifdef BOOT_CHECKSUM_EN
                r_state <= ST_CSUM;
`else
                r_state <= ST_DONE;
`endif
              end
            end
          end
          ST_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
            r_state <= (w_byte == r_csum) ? ST_DONE : ST_ERR;
`else
            r_state <= ST_ERR;
`endif
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: status lines decode straight from the registered state.
  // --------------------------------------------------------------------------
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = w_busy;
  assign bus.done      = (r_state == ST_DONE);
  assign bus.err       = (r_state == ST_ERR);
  assign bus.cpu_rst   = (r_state != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_boot_loader
//  Purpose : Self-checking bench for uart_boot_loader. A frame-level model
//            (byte queue, per-byte timestamps) predicts writes and status
//            every cycle; directed frames add hand-computed expectations.
//  Config  : BOOT_CHECKSUM_EN enables the checksum frames.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;
  localparam int TIMEOUT   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_boot_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Frame-level model. Phases: 0 never loaded, 1 in frame, 2 done, 3 error.
  // A byte takes effect one clock after rx_en is seen rising.
  // --------------------------------------------------------------------------
  int                m_cyc   = 0;
  bit                m_prev  = 1'b1;
  bit                m_pend  = 1'b0;
  logic [7:0]        m_pbyte = 8'h00;
  int                m_phase = 0;
  logic [7:0]        m_bytes[$];
  int                m_len   = 0;
  int                m_last  = 0;
  bit                e_we    = 1'b0;
  logic [ADDR_W-1:0] e_addr  = '0;
  logic [31:0]       e_data  = '0;

  task automatic model_byte(input logic [7:0] b);
    int n;
    int w;
    logic [7:0] x;
    if (m_phase != 1) begin
      m_bytes.delete();
      m_phase = 1;
    end
    m_bytes.push_back(b);
    m_last = m_cyc;
    n = m_bytes.size();
    if (n == 2) begin
      m_len = m_bytes[0] + 256 * m_bytes[1];
      if (m_len == 0) m_phase = 2;
      else if (m_len > (1 << ADDR_W)) m_phase = 3;
    end else if (n > 2 && n <= 2 + 4 * m_len) begin
      if ((n - 2) % 4 == 0) begin
        w      = (n - 2) / 4 - 1;
        e_we   = 1'b1;
        e_addr = ADDR_W'((BASE_ADDR + w) % (1 << ADDR_W));
        e_data = {m_bytes[n-1], m_bytes[n-2], m_bytes[n-3], m_bytes[n-4]};
`ifndef BOOT_CHECKSUM_EN
        if (n == 2 + 4 * m_len) m_phase = 2;
`endif
      end
    end
`ifdef BOOT_CHECKSUM_EN
    else if (n == 3 + 4 * m_len) begin
      x = 8'h00;
      for (int i = 0; i < n - 1; i++) x ^= m_bytes[i];
      m_phase = (x == b) ? 2 : 3;
    end
`endif
    x = 8'h00;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc   = 0;
      m_prev  = 1'b1;
      m_pend  = 1'b0;
      m_phase = 0;
      m_bytes.delete();
      e_we    = 1'b0;
      e_addr  = ADDR_W'(BASE_ADDR);
    end else begin
      m_cyc++;
      e_we = 1'b0;
      if (m_phase == 1 && (m_cyc - m_last) >= TIMEOUT) m_phase = 3;
      else if (m_pend) model_byte(m_pbyte);
      m_pend  = bus.rx_en && !m_prev;
      m_prev  = bus.rx_en;
      m_pbyte = bus.rx_data;
    end
  end

  // Write log of what the DUT actually wrote, for the literal checks.
  logic [ADDR_W-1:0] log_a[$];
  logic [31:0]       log_d[$];

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("mem_we", bus.mem_we, e_we);
      if (e_we) begin
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_wdata", bus.mem_wdata, e_data);
      end
      check("done", bus.done, m_phase == 2);
      check("err", bus.err, m_phase == 3);
      check("busy", bus.busy, m_phase == 1);
      check("cpu_rst", bus.cpu_rst, m_phase != 2);
      if (bus.mem_we) begin
        log_a.push_back(bus.mem_addr);
        log_d.push_back(bus.mem_wdata);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [7:0] tx_q[$];
  logic [7:0] last_csum;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_en   = 1'b0;
    @(negedge clk);
    bus.rx_en   = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Sends tx_q[first..]; the checksum (optionally corrupted) covers all of tx_q.
  task automatic send_q(input bit with_csum, input logic [7:0] flip, input int first);
    logic [7:0] x;
    x = 8'h00;
    foreach (tx_q[i]) x ^= tx_q[i];
    last_csum = x ^ flip;
    for (int i = first; i < tx_q.size(); i++) send_byte(tx_q[i]);
`ifdef BOOT_CHECKSUM_EN
    if (with_csum) send_byte(last_csum);
`else
    if (with_csum) last_csum = x;
`endif
  endtask

  task automatic check_log1(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    check({name, "_nwr"}, log_a.size(), 1);
    if (log_a.size() > 0) begin
      check({name, "_addr"}, log_a[0], a);
      check({name, "_data"}, log_d[0], d);
    end
  endtask

  initial begin
    bus.rx_en   = 1'b1;
    bus.rx_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, BASE_ADDR);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_rst", bus.cpu_rst, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);

    // Two-word program.
    log_a.delete(); log_d.delete();
    tx_q = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_q(1'b1, 8'h00, 0);
    check("t1_nwr", log_a.size(), 2);
    if (log_a.size() >= 2) begin
      check("t1_a0", log_a[0], 0);
      check("t1_d0", log_d[0], 32'h0000_0013);
      check("t1_a1", log_a[1], 1);
      check("t1_d1", log_d[1], 32'h0010_0093);
    end
    check("t1_done", bus.done, 1);
    check("t1_cpu_rst", bus.cpu_rst, 0);

    // Reload from DONE.
    log_a.delete(); log_d.delete();
    tx_q = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_byte(tx_q[0]);
    check("t5_cpu_rst_lenlo", bus.cpu_rst, 1);
    check("t5_done_lenlo", bus.done, 0);
    check("t5_busy_lenlo", bus.busy, 1);
    send_q(1'b1, 8'h00, 1);
    check_log1("t5", 0, 32'hDEAD_BEEF);
    check("t5_done", bus.done, 1);

    // Empty frame.
    log_a.delete(); log_d.delete();
    send_byte(8'h00);
    send_byte(8'h00);
    check("t2_nwr", log_a.size(), 0);
    check("t2_done", bus.done, 1);
    check("t2_cpu_rst", bus.cpu_rst, 0);

    // Timeout with a partial word.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TIMEOUT + 5) @(negedge clk);
    check("t3_err", bus.err, 1);
    check("t3_busy", bus.busy, 0);
    check("t3_cpu_rst", bus.cpu_rst, 1);
    check("t3_nwr", log_a.size(), 0);
    send_byte(8'h01);
    check("t3_err_clr", bus.err, 0);
    check("t3_busy_new", bus.busy, 1);

    // Length 0x0401 exceeds 1024 words.
    send_byte(8'h04);
    check("t4_err", bus.err, 1);
    check("t4_busy", bus.busy, 0);
    check("t4_nwr", log_a.size(), 0);

`ifdef BOOT_CHECKSUM_EN
    log_a.delete(); log_d.delete();
    tx_q = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_q(1'b1, 8'h00, 0);
    check("t6_csum_val", last_csum, 8'h05);
    check("t6_done", bus.done, 1);
    check_log1("t6", 0, 32'h0403_0201);
    log_a.delete(); log_d.delete();
    send_q(1'b1, 8'h03, 0);
    check("t6_bad_csum_val", last_csum, 8'h06);
    check("t6_bad_err", bus.err, 1);
    check("t6_bad_cpu_rst", bus.cpu_rst, 1);
    check_log1("t6_bad", 0, 32'h0403_0201);
`endif

    // Asynchronous reset mid-DATA.
    log_a.delete(); log_d.delete();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    check("ar_mem_we", bus.mem_we, 0);
    check("ar_mem_addr", bus.mem_addr, BASE_ADDR);
    check("ar_mem_wdata", bus.mem_wdata, 0);
    check("ar_cpu_rst", bus.cpu_rst, 1);
    check("ar_busy", bus.busy, 0);
    check("ar_done", bus.done, 0);
    check("ar_err", bus.err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("ar_nwr", log_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
